cpu_sequencer: RTL and testbench

//  Multi-cycle fetch/decode/execute control plus 4x8 register file and Z/N flags register for the 8-bit CPU.

---
 rtl/cpu_sequencer_if.sv | 29 ++
 rtl/cpu_sequencer.sv | 146 ++++++++++++++
 tb/tb_cpu_sequencer.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_sequencer_if.sv
// Bus bundle between the CPU sequencer and its environment:
// instruction memory port, ALU operand/result port, status flags and debug read port.
interface cpu_sequencer_if;
    logic [7:0] imem_addr;
    logic [7:0] imem_data;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [1:0] alu_op;
    logic [7:0] alu_result;
    logic       alu_zero;
    logic       alu_neg;
    logic       halted;
    logic       flag_z;
    logic       flag_n;
    logic [1:0] dbg_sel;
    logic [7:0] dbg_data;

    // Sequencer side
    modport master (
        output imem_addr, alu_a, alu_b, alu_op, halted, flag_z, flag_n, dbg_data,
        input  imem_data, alu_result, alu_zero, alu_neg, dbg_sel
    );

    // Environment side (memory, ALU, debug host)
    modport slave (
        input  imem_addr, alu_a, alu_b, alu_op, halted, flag_z, flag_n, dbg_data,
        output imem_data, alu_result, alu_zero, alu_neg, dbg_sel
    );
endinterface

// File: rtl/cpu_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer for the 8-bit CPU.
// Owns pc, ir, the 4x8 register file and the Z/N flags; the ALU itself is external.
module cpu_sequencer #(
    parameter logic [7:0] RESET_PC = 8'h00,
    parameter int         NUM_REGS = 4
) (
    input  logic            clk,
    input  logic            rst,
    cpu_sequencer_if.master bus
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_IMM,
        S_HALT
    } state_t;

    localparam logic [1:0] CLS_ALU  = 2'b00;
    localparam logic [1:0] CLS_LDI  = 2'b01;
    localparam logic [1:0] CLS_BR   = 2'b10;

    state_t     state_q, state_d;
    logic [7:0] pc_q, pc_d;
    logic [7:0] ir_q, ir_d;
    logic [7:0] regs_q [NUM_REGS];
    logic [7:0] regs_d [NUM_REGS];
    logic       flag_z_q, flag_z_d;
    logic       flag_n_q, flag_n_d;
    logic       halted_q, halted_d;

    logic [1:0] cls;
    logic [1:0] cc;
    logic [1:0] rd;
    logic [1:0] rs;
    logic       br_taken;

    assign cls = ir_q[7:6];
    assign cc  = ir_q[5:4];
    assign rd  = ir_q[3:2];
    assign rs  = ir_q[1:0];

    // Branch condition evaluated against the flags as currently latched
    always_comb begin
        br_taken = 1'b0;
        case (cc)
            2'b00: br_taken = 1'b1;
            2'b01: br_taken = flag_z_q;
            2'b10: br_taken = flag_n_q;
            2'b11: br_taken = ~flag_z_q;
            default: br_taken = 1'b0;
        endcase
    end

    // Next-state logic for the control FSM and all architectural state
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        regs_d   = regs_q;
        flag_z_d = flag_z_q;
        flag_n_d = flag_n_q;
        halted_d = halted_q;
        case (state_q)
            S_FETCH: begin
                // Memory is sampling imem_addr=pc this cycle; data arrives in DECODE
                state_d = S_DECODE;
            end
            S_DECODE: begin
                ir_d    = bus.imem_data;
                pc_d    = pc_q + 8'd1;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                case (cls)
                    CLS_ALU: begin
                        regs_d[rd] = bus.alu_result;
                        flag_z_d   = bus.alu_zero;
                        flag_n_d   = bus.alu_neg;
                        state_d    = S_FETCH;
                    end
                    CLS_LDI, CLS_BR: begin
                        // pc already points at the immediate byte; let memory fetch it
                        state_d = S_IMM;
                    end
                    default: begin
                        halted_d = 1'b1;
                        state_d  = S_HALT;
                    end
                endcase
            end
            S_IMM: begin
                if (cls == CLS_LDI) begin
                    regs_d[rd] = bus.imem_data;
                    pc_d       = pc_q + 8'd1;
                end else if (br_taken) begin
                    pc_d = bus.imem_data;
                end else begin
                    pc_d = pc_q + 8'd1;
                end
                state_d = S_FETCH;
            end
            S_HALT: begin
                // Terminal: everything frozen until reset
                state_d = S_HALT;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // State registers with synchronous reset; reset aborts any instruction in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_FETCH;
            pc_q     <= RESET_PC;
            ir_q     <= 8'h00;
            flag_z_q <= 1'b0;
            flag_n_q <= 1'b0;
            halted_q <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= 8'h00;
            end
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            flag_z_q <= flag_z_d;
            flag_n_q <= flag_n_d;
            halted_q <= halted_d;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    assign bus.imem_addr = pc_q;
    assign bus.alu_a     = regs_q[rd];
    assign bus.alu_b     = regs_q[rs];
    assign bus.alu_op    = ir_q[5:4];
    assign bus.halted    = halted_q;
    assign bus.flag_z    = flag_z_q;
    assign bus.flag_n    = flag_n_q;
    assign bus.dbg_data  = regs_q[bus.dbg_sel];

endmodule

// File: tb/tb_cpu_sequencer.sv
// Scoreboard bench for cpu_sequencer: directed programs, expected architectural
// state queued by the stimulus and compared by monitors on halt or probe events.
module tb_cpu_sequencer;

    typedef struct {
        int         id;
        int         cyc;
        logic [7:0] r0, r1, r2, r3;
        logic       z, n, h;
        logic [7:0] pc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a = 1'b1;
    logic rst_b = 1'b1;
    logic probe_a = 1'b0;
    logic probe_b = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   done_a = 0;
    int   done_b = 0;
    int   cyc_a = 0;
    int   cyc_b = 0;
    exp_t qa[$];
    exp_t qb[$];
    logic [7:0] mem_a [256];
    logic [7:0] mem_b [256];

    cpu_sequencer_if ifa ();
    cpu_sequencer_if ifb ();

    cpu_sequencer #(.RESET_PC(8'h00)) u_dut_a (.clk(clk), .rst(rst_a), .bus(ifa.master));
    cpu_sequencer #(.RESET_PC(8'hFE)) u_dut_b (.clk(clk), .rst(rst_b), .bus(ifb.master));

    function automatic logic [7:0] alu_f(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            2'b00:   return a + b;
            2'b01:   return a - b;
            2'b10:   return a & b;
            default: return ~a;
        endcase
    endfunction

    // Synchronous-read instruction memories and combinational ALU models
    always @(posedge clk) ifa.imem_data <= mem_a[ifa.imem_addr];
    always @(posedge clk) ifb.imem_data <= mem_b[ifb.imem_addr];
    assign ifa.alu_result = alu_f(ifa.alu_op, ifa.alu_a, ifa.alu_b);
    assign ifa.alu_zero   = (ifa.alu_result == 8'h00);
    assign ifa.alu_neg    = ifa.alu_result[7];
    assign ifb.alu_result = alu_f(ifb.alu_op, ifb.alu_a, ifb.alu_b);
    assign ifb.alu_zero   = (ifb.alu_result == 8'h00);
    assign ifb.alu_neg    = ifb.alu_result[7];

    // Cycles since reset release (first edge with rst low counts as 1)
    always @(posedge clk) cyc_a <= rst_a ? 0 : cyc_a + 1;
    always @(posedge clk) cyc_b <= rst_b ? 0 : cyc_b + 1;

    function automatic exp_t mk(input int id, input int cyc,
                                input logic [7:0] r0, input logic [7:0] r1,
                                input logic [7:0] r2, input logic [7:0] r3,
                                input logic z, input logic n, input logic h,
                                input logic [7:0] pc);
        exp_t e;
        e.id = id; e.cyc = cyc;
        e.r0 = r0; e.r1 = r1; e.r2 = r2; e.r3 = r3;
        e.z = z; e.n = n; e.h = h; e.pc = pc;
        return e;
    endfunction

    task automatic chk(input int id, input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL t%0d %s: got %0h expected %0h", id, nm, act, exp);
        end
    endtask

    task automatic cmp(input exp_t e, input int cyc, input logic [3:0][7:0] g,
                       input logic z, input logic n, input logic h, input logic [7:0] pc);
        if (e.cyc >= 0) chk(e.id, "halt_cycle", cyc, e.cyc);
        chk(e.id, "r0", {24'd0, g[0]}, {24'd0, e.r0});
        chk(e.id, "r1", {24'd0, g[1]}, {24'd0, e.r1});
        chk(e.id, "r2", {24'd0, g[2]}, {24'd0, e.r2});
        chk(e.id, "r3", {24'd0, g[3]}, {24'd0, e.r3});
        chk(e.id, "flag_z", {31'd0, z}, {31'd0, e.z});
        chk(e.id, "flag_n", {31'd0, n}, {31'd0, e.n});
        chk(e.id, "halted", {31'd0, h}, {31'd0, e.h});
        chk(e.id, "pc", {24'd0, pc}, {24'd0, e.pc});
    endtask

    // Monitor A: compares on halted rising edge or on an explicit probe
    initial begin
        logic hprev;
        logic [3:0][7:0] g;
        exp_t e;
        hprev = 1'b0;
        ifa.dbg_sel = 2'd0;
        forever begin
            @(negedge clk);
            if (!rst_a && ((ifa.halted && !hprev) || probe_a)) begin
                for (int i = 0; i < 4; i++) begin
                    ifa.dbg_sel = 2'(i);
                    #1;
                    g[i] = ifa.dbg_data;
                end
                if (qa.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL dut_a event: no expected entry queued");
                end else begin
                    e = qa.pop_front();
                    cmp(e, cyc_a, g, ifa.flag_z, ifa.flag_n, ifa.halted, ifa.imem_addr);
                end
                done_a++;
            end
            hprev = ifa.halted;
        end
    end

    // Monitor B: same checks for the RESET_PC=FE instance
    initial begin
        logic hprev;
        logic [3:0][7:0] g;
        exp_t e;
        hprev = 1'b0;
        ifb.dbg_sel = 2'd0;
        forever begin
            @(negedge clk);
            if (!rst_b && ((ifb.halted && !hprev) || probe_b)) begin
                for (int i = 0; i < 4; i++) begin
                    ifb.dbg_sel = 2'(i);
                    #1;
                    g[i] = ifb.dbg_data;
                end
                if (qb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL dut_b event: no expected entry queued");
                end else begin
                    e = qb.pop_front();
                    cmp(e, cyc_b, g, ifb.flag_z, ifb.flag_n, ifb.halted, ifb.imem_addr);
                end
                done_b++;
            end
            hprev = ifb.halted;
        end
    end

    task automatic wait_a(input int target, input int budget);
        bit ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(posedge clk);
            if (done_a >= target) ok = 1'b1;
        end
        #1;
        if (!ok) begin
            checks++; errors++;
            $display("FAIL dut_a timeout: got %0d events expected %0d", done_a, target);
            qa.delete();
        end
    endtask

    task automatic wait_b(input int target, input int budget);
        bit ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(posedge clk);
            if (done_b >= target) ok = 1'b1;
        end
        #1;
        if (!ok) begin
            checks++; errors++;
            $display("FAIL dut_b timeout: got %0d events expected %0d", done_b, target);
            qb.delete();
        end
    endtask

    task automatic expect_halt_a(input exp_t e);
        qa.push_back(e);
        wait_a(done_a + 1, 100);
    endtask

    task automatic probe_now_a(input exp_t e);
        int target;
        target = done_a + 1;
        qa.push_back(e);
        probe_a = 1'b1;
        @(posedge clk);
        #1 probe_a = 1'b0;
        wait_a(target, 2);
    endtask

    task automatic reset_a();
        rst_a = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_a = 1'b0;
    endtask

    task automatic clear_a();
        for (int i = 0; i < 256; i++) mem_a[i] = 8'hC0;
    endtask

    initial begin
        int target;
        for (int i = 0; i < 256; i++) mem_b[i] = 8'hC0;
        clear_a();

        // T1: LDI r0,1; LDI r1,3; ADD r0,r1; HALT
        mem_a[0] = 8'h40; mem_a[1] = 8'h01; mem_a[2] = 8'h44; mem_a[3] = 8'h03;
        mem_a[4] = 8'h01; mem_a[5] = 8'hC0;
        reset_a();
        probe_now_a(mk(0, -1, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00));
        expect_halt_a(mk(1, 14, 8'h04, 8'h03, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 8'h06));

        // T6: state frozen across 20 halted cycles
        repeat (20) @(posedge clk);
        #1;
        probe_now_a(mk(6, -1, 8'h04, 8'h03, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 8'h06));

        // T2: 100+100 sets N; BZ falls through, BN taken to 0x20
        clear_a();
        mem_a[0] = 8'h40; mem_a[1] = 8'h64; mem_a[2] = 8'h44; mem_a[3] = 8'h64;
        mem_a[4] = 8'h01; mem_a[5] = 8'h90; mem_a[6] = 8'h30; mem_a[7] = 8'hA0;
        mem_a[8] = 8'h20; mem_a[8'h30] = 8'h48; mem_a[8'h31] = 8'h55;
        reset_a();
        expect_halt_a(mk(2, 22, 8'hC8, 8'h64, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 8'h21));

        // T3: 50-50 sets Z; BNZ not taken
        clear_a();
        mem_a[0] = 8'h40; mem_a[1] = 8'h32; mem_a[2] = 8'h44; mem_a[3] = 8'h32;
        mem_a[4] = 8'h11; mem_a[5] = 8'hB0; mem_a[6] = 8'h40; mem_a[7] = 8'hC0;
        mem_a[8'h40] = 8'h48; mem_a[8'h41] = 8'hAA;
        reset_a();
        expect_halt_a(mk(3, 18, 8'h00, 8'h32, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 8'h08));

        // T7: NOT r3 with rd==rs, then LDI leaves N untouched
        clear_a();
        mem_a[0] = 8'h4C; mem_a[1] = 8'h0F; mem_a[2] = 8'h3F; mem_a[3] = 8'h48;
        mem_a[4] = 8'h00; mem_a[5] = 8'hC0;
        reset_a();
        expect_halt_a(mk(7, 14, 8'h00, 8'h00, 8'h00, 8'hF0, 1'b0, 1'b1, 1'b1, 8'h06));

        // T5: reset lands on EXEC of ADD r0,r1; program then reruns cleanly
        clear_a();
        mem_a[0] = 8'h40; mem_a[1] = 8'h01; mem_a[2] = 8'h44; mem_a[3] = 8'h03;
        mem_a[4] = 8'h01; mem_a[5] = 8'hC0;
        reset_a();
        repeat (10) @(posedge clk);
        #1 rst_a = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_a = 1'b0;
        probe_now_a(mk(5, -1, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00));
        expect_halt_a(mk(8, 14, 8'h04, 8'h03, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 8'h06));

        // T4: RESET_PC=FE, immediate at FF, fetch wraps to 00
        mem_b[8'hFE] = 8'h40; mem_b[8'hFF] = 8'h7F; mem_b[8'h00] = 8'hC0;
        rst_b = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_b = 1'b0;
        target = done_b + 1;
        qb.push_back(mk(40, -1, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'hFE));
        probe_b = 1'b1;
        @(posedge clk);
        #1 probe_b = 1'b0;
        wait_b(target, 2);
        qb.push_back(mk(4, 7, 8'h7F, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 8'h01));
        wait_b(done_b + 1, 100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
